// File: rtl/smart_home_pkg.sv
// Purpose: shared constants, state type and helpers for the smart-home sensor conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package smart_home_pkg;

    // Temperature sample width and the value shown before the first full window
    localparam int                TEMP_W     = 7;
    localparam logic [TEMP_W-1:0] TEMP_RESET = 7'd50;

    // Comfort band: temperatures strictly between these limits request neither heat nor cooling
    localparam logic [TEMP_W-1:0] TEMP_LOW   = 7'd33;
    localparam logic [TEMP_W-1:0] TEMP_HIGH  = 7'd71;

    // Debounce counter width; large enough for the maximum debounce length of 255
    localparam int                DB_CNT_W   = 8;

    // Temperature averaging FSM
    typedef enum logic {
        TS_WARMUP = 1'b0,
        TS_RUN    = 1'b1
    } temp_state_t;

    // True when a temperature lies inside the comfort band
    function automatic logic in_comfort_band(input logic [TEMP_W-1:0] t);
        return (t > TEMP_LOW) && (t < TEMP_HIGH);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// Purpose: one binary sensor channel -- two-flop synchronizer followed by a stability debouncer.
// Latency: output follows a clean raw edge after 2+DEBOUNCE_CYCLES cycles (rising edge after 2 with FAST_RISE).
// Backpressure: none; the raw input is sampled every cycle.
module debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit FAST_RISE       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_out
);
    import smart_home_pkg::*;

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_out;
    logic [DB_CNT_W-1:0] r_cnt;

    logic                w_differs;
    logic                w_fast_set;

    assign w_differs  = (r_sync2 != r_out);
    // A synchronized assertion on a fast-rise channel is taken without waiting
    assign w_fast_set = FAST_RISE && r_sync2 && !r_out;

    // Two-flop synchronizer; nothing downstream looks at i_raw directly
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing cycles; adopt the new level once the run is long enough
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (w_fast_set) begin
            r_cnt <= '0;
            r_out <= 1'b1;
        end else if (!w_differs) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_out <= r_sync2;
        end else begin
            r_cnt <= r_cnt + DB_CNT_W'(1);
        end
    end

    // The fast path shows the synchronized assertion in the same cycle the register is being set,
    // so a fire alarm appears two cycles after the raw edge; release always goes through r_out.
    assign o_out = r_out | (FAST_RISE && r_sync2);

endmodule

// File: rtl/sensor_conditioner.sv
// Purpose: conditions door/window/fire contacts and produces a windowed temperature average.
// Latency: binary 2+DEBOUNCE_CYCLES cycles (fire rise 2); ST one cycle after the completing sample.
// Backpressure: none; every temp_valid strobe is accepted.
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AVG_LOG2        = 2
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       raw_fd,
    input  logic       raw_rd,
    input  logic       raw_w,
    input  logic       raw_fa,
    input  logic [6:0] temp_in,
    input  logic       temp_valid,
    output logic       SFD,
    output logic       SRD,
    output logic       SW,
    output logic       SFA,
    output logic [6:0] ST,
    output logic       st_update
);
    import smart_home_pkg::*;

    // Accumulator holds up to 2^AVG_LOG2 full-scale samples, so it can never overflow.
    localparam int ACC_W = TEMP_W + AVG_LOG2;
    // A window of one sample needs no counter; keep a single tied-off bit so widths stay legal.
    localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    // ------------------------------------------------------------------
    // Binary channels
    // ------------------------------------------------------------------
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FAST_RISE(1'b0)) u_db_fd (
        .i_clk (clk),
        .i_rst (Rst),
        .i_raw (raw_fd),
        .o_out (SFD)
    );

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FAST_RISE(1'b0)) u_db_rd (
        .i_clk (clk),
        .i_rst (Rst),
        .i_raw (raw_rd),
        .o_out (SRD)
    );

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FAST_RISE(1'b0)) u_db_w (
        .i_clk (clk),
        .i_rst (Rst),
        .i_raw (raw_w),
        .o_out (SW)
    );

    // Fire alarm: assertion is safety-critical and skips the debounce, release is debounced
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .FAST_RISE(1'b1)) u_db_fa (
        .i_clk (clk),
        .i_rst (Rst),
        .i_raw (raw_fa),
        .o_out (SFA)
    );

    // ------------------------------------------------------------------
    // Temperature averaging
    // ------------------------------------------------------------------
    temp_state_t       r_state;
    temp_state_t       w_state_nxt;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [TEMP_W-1:0] r_st;
    logic              r_st_update;

    logic [ACC_W-1:0]  w_sum;
    logic [TEMP_W-1:0] w_avg;
    logic              w_complete;

    assign w_sum      = r_acc + ACC_W'(temp_in);
    // Dividing by the window size is a plain truncating right shift
    assign w_avg      = w_sum[AVG_LOG2 +: TEMP_W];
    assign w_complete = temp_valid && (r_cnt == CNT_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state <= TS_WARMUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave warm-up on the first completed window, then stay in RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TS_WARMUP: if (w_complete) w_state_nxt = TS_RUN;
            TS_RUN:    w_state_nxt = TS_RUN;
            default:   w_state_nxt = TS_WARMUP;
        endcase
    end

    // Window accumulation; a completing sample publishes the average and restarts the window
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_st        <= TEMP_RESET;
            r_st_update <= 1'b0;
        end else begin
            r_st_update <= w_complete;
            if (w_complete) begin
                r_st  <= w_avg;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (temp_valid) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign ST        = r_st;
    assign st_update = r_st_update;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Purpose: directed and randomized check of sensor_conditioner against a behavioural model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_sensor_conditioner;
    import smart_home_pkg::*;

    localparam int D = 4;
    localparam int L = 2;
    localparam int N = 1 << L;

    logic       clk = 1'b0;
    logic       Rst;
    logic [3:0] raw;          // 0 front door, 1 rear door, 2 window, 3 fire alarm
    logic [6:0] temp_in;
    logic       temp_valid;
    logic       SFD, SRD, SW, SFA;
    logic [6:0] ST;
    logic       st_update;

    always #5 clk = ~clk;

    sensor_conditioner #(.DEBOUNCE_CYCLES(D), .AVG_LOG2(L)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .raw_fd     (raw[0]),
        .raw_rd     (raw[1]),
        .raw_w      (raw[2]),
        .raw_fa     (raw[3]),
        .temp_in    (temp_in),
        .temp_valid (temp_valid),
        .SFD        (SFD),
        .SRD        (SRD),
        .SW         (SW),
        .SFA        (SFA),
        .ST         (ST),
        .st_update  (st_update)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: raw history per channel, the level each output has settled to,
    // the length of the current disagreeing run, and the list of samples in the open window.
    logic [3:0] h1, h2, h3;   // raw value applied 1, 2 and 3 cycles before the current edge
    logic [3:0] mout;
    int         run [4];
    int         q [$];
    logic [6:0] exp_st;
    logic       exp_upd;
    int         hold [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance one clock, update the model from the inputs that edge saw, compare every output
    task automatic step();
        int sum;
        @(posedge clk);
        #1;
        if (Rst) begin
            h1 = '0; h2 = '0; h3 = '0; mout = '0;
            for (int c = 0; c < 4; c++) run[c] = 0;
            q.delete();
            exp_st  = TEMP_RESET;
            exp_upd = 1'b0;
        end else begin
            h3 = h2; h2 = h1; h1 = raw;
            for (int c = 0; c < 4; c++) begin
                if (c == 3 && h3[c] && !mout[c]) begin
                    mout[c] = 1'b1;
                    run[c]  = 0;
                end else if (h3[c] != mout[c]) begin
                    run[c]++;
                    if (run[c] == D) begin
                        mout[c] = h3[c];
                        run[c]  = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
            exp_upd = 1'b0;
            if (temp_valid) begin
                q.push_back(int'(temp_in));
                if (q.size() == N) begin
                    sum = 0;
                    foreach (q[i]) sum += q[i];
                    exp_st  = 7'(sum / N);
                    exp_upd = 1'b1;
                    q.delete();
                end
            end
        end
        chk("model_SFD", 32'(SFD), 32'(mout[0]));
        chk("model_SRD", 32'(SRD), 32'(mout[1]));
        chk("model_SW",  32'(SW),  32'(mout[2]));
        chk("model_SFA", 32'(SFA), 32'(mout[3] | h2[3]));
        chk("model_ST",  32'(ST),  32'(exp_st));
        chk("model_upd", 32'(st_update), 32'(exp_upd));
    endtask

    task automatic send(input int v);
        temp_valid = 1'b1;
        temp_in    = 7'(v);
        step();
    endtask

    initial begin
        Rst = 1'b1; raw = '0; temp_in = '0; temp_valid = 1'b0;
        h1 = '0; h2 = '0; h3 = '0; mout = '0;
        exp_st = TEMP_RESET; exp_upd = 1'b0;
        for (int c = 0; c < 4; c++) begin run[c] = 0; hold[c] = 0; end

        // Reset for two cycles, then idle
        step();
        step();
        Rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_bin", 32'({SFD, SRD, SW, SFA}), 32'd0);
            chk("idle_st",  32'(ST), 32'd50);
            chk("idle_upd", 32'(st_update), 32'd0);
        end
        chk("idle_fsm", 32'(dut.r_state), 32'(TS_WARMUP));

        // Rear door: clean rise lands exactly 2+D cycles later
        raw[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("srd_rise", 32'(SRD), 32'(i >= 6));
        end
        raw[1] = 1'b0;
        repeat (10) step();
        chk("srd_fall", 32'(SRD), 32'd0);
        // Rear door: 3-cycle pulse is a glitch
        raw[1] = 1'b1;
        repeat (3) step();
        raw[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("srd_glitch", 32'(SRD), 32'd0);
        end

        // Fire alarm: fast rise, debounced fall, dropout ignored
        raw[3] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("sfa_rise", 32'(SFA), 32'(i >= 2));
        end
        repeat (6) step();
        raw[3] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("sfa_fall", 32'(SFA), 32'(i < 6));
        end
        raw[3] = 1'b1;
        repeat (8) step();
        raw[3] = 1'b0;
        step();
        raw[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("sfa_dropout", 32'(SFA), 32'd1);
        end
        raw[3] = 1'b0;
        repeat (10) step();

        // First window: 20,21,22,24 -> 87/4 = 21
        send(20);
        send(21);
        send(22);
        chk("warm_st", 32'(ST), 32'd50);
        send(24);
        chk("avg_st",  32'(ST), 32'd21);
        chk("avg_upd", 32'(st_update), 32'd1);
        temp_valid = 1'b0;
        step();
        chk("avg_upd_off", 32'(st_update), 32'd0);
        chk("fsm_run",     32'(dut.r_state), 32'(TS_RUN));
        // Three more samples leave ST alone, the fourth completes (30+40+50+0)/4 = 30
        send(30);
        send(40);
        send(50);
        temp_valid = 1'b0;
        step();
        chk("partial_st",  32'(ST), 32'd21);
        chk("partial_upd", 32'(st_update), 32'd0);
        send(0);
        chk("second_st", 32'(ST), 32'd30);

        // Full-scale window, then truncation
        send(127); send(127); send(127); send(127);
        chk("max_st", 32'(ST), 32'd127);
        send(0); send(0); send(0); send(3);
        chk("trunc_st", 32'(ST), 32'd0);
        temp_valid = 1'b0;
        step();

        // Reset beats a sample on the same edge and discards the partial window
        send(60);
        send(60);
        Rst = 1'b1;
        send(60);
        Rst = 1'b0;
        temp_valid = 1'b0;
        chk("rst_st",  32'(ST), 32'd50);
        chk("rst_upd", 32'(st_update), 32'd0);
        chk("rst_fsm", 32'(dut.r_state), 32'(TS_WARMUP));
        send(80); send(80); send(80); send(80);
        chk("after_rst_st", 32'(ST), 32'd80);
        temp_valid = 1'b0;
        step();

        // Randomized traffic on all channels at once
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    raw[c]  = 1'($urandom_range(1, 0));
                    hold[c] = int'($urandom_range(7, 1));
                end
                hold[c]--;
            end
            temp_valid = 1'($urandom_range(1, 0));
            temp_in    = 7'($urandom_range(127, 0));
            step();
        end
        temp_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
